// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: one-at-a-time div/mod sequencer between the EX-stage ALU and
// the signed (sdiv) and unsigned (udiv) pipelined divider IPs.
// Optional build macro DIV_PAIR_CACHE_EN: keeps the last good IP result so a
// div followed by mod on the same operands completes without an IP round trip.
module div_issue_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  output logic        sdiv_dividend_tvalid,
  output logic        sdiv_divisor_tvalid,
  input  logic        sdiv_dividend_tready,
  input  logic        sdiv_divisor_tready,
  input  logic [63:0] sdiv_dout_tdata,
  input  logic        sdiv_dout_tvalid,
  output logic        udiv_dividend_tvalid,
  output logic        udiv_divisor_tvalid,
  input  logic        udiv_dividend_tready,
  input  logic        udiv_divisor_tready,
  input  logic [63:0] udiv_dout_tdata,
  input  logic        udiv_dout_tvalid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src1_q, src1_d, src2_q, src2_d;
  logic [3:0]       op_q, op_d;
  logic             kill_q, kill_d;
  logic             dvd_acc_q, dvd_acc_d, dvs_acc_q, dvs_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;

  // op bits are {modu, mod, divu, div}: signed = div|mod, quotient = div|divu
  logic req_signed, req_quot, req_onehot, sel_signed, sel_quot;
  assign req_signed = req_op[0] | req_op[2];
  assign req_quot   = req_op[0] | req_op[1];
  assign req_onehot = $onehot(req_op);
  assign sel_signed = op_q[0] | op_q[2];
  assign sel_quot   = op_q[0] | op_q[1];

  // Per-channel issue valids are derived from state so they drop the cycle
  // after each channel's own handshake.
  logic        dvd_tvalid, dvs_tvalid, dvd_tready, dvs_tready;
  logic        dvd_done, dvs_done, sel_dout_tvalid, timeout;
  logic [63:0] sel_dout_tdata;
  logic [31:0] sel_half;
  logic [CNT_W-1:0] cnt_inc;

  assign dvd_tvalid      = (state_q == S_ISSUE) && !dvd_acc_q;
  assign dvs_tvalid      = (state_q == S_ISSUE) && !dvs_acc_q;
  assign dvd_tready      = sel_signed ? sdiv_dividend_tready : udiv_dividend_tready;
  assign dvs_tready      = sel_signed ? sdiv_divisor_tready  : udiv_divisor_tready;
  assign dvd_done        = dvd_acc_q | (dvd_tvalid & dvd_tready);
  assign dvs_done        = dvs_acc_q | (dvs_tvalid & dvs_tready);
  assign sel_dout_tvalid = sel_signed ? sdiv_dout_tvalid : udiv_dout_tvalid;
  assign sel_dout_tdata  = sel_signed ? sdiv_dout_tdata  : udiv_dout_tdata;
  assign sel_half        = sel_quot ? sel_dout_tdata[63:32] : sel_dout_tdata[31:0];
  assign cnt_inc         = cnt_q + 1'b1;
  assign timeout         = (cnt_inc == CNT_W'(MAX_WAIT));

  logic        cache_hit;
  logic [63:0] cache_dout;
`ifdef DIV_PAIR_CACHE_EN
  logic        cache_vld_q, cache_signed_q, cache_wr;
  logic [31:0] cache_src1_q, cache_src2_q;
  logic [63:0] cache_dout_q;

  // only a normal, non-killed WAIT completion refreshes the entry
  assign cache_wr   = (state_q == S_WAIT) && sel_dout_tvalid && !kill_q && !flush;
  assign cache_hit  = cache_vld_q && (cache_src1_q == req_src1) &&
                      (cache_src2_q == req_src2) && (cache_signed_q == req_signed);
  assign cache_dout = cache_dout_q;

  // result cache register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cache_vld_q    <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_src1_q   <= '0;
      cache_src2_q   <= '0;
      cache_dout_q   <= '0;
    end else if (cache_wr) begin
      cache_vld_q    <= 1'b1;
      cache_signed_q <= sel_signed;
      cache_src1_q   <= src1_q;
      cache_src2_q   <= src2_q;
      cache_dout_q   <= sel_dout_tdata;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_dout = '0;
`endif

  // next-state and datapath updates for the request/issue/wait/response FSM
  always_comb begin
    state_d   = state_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    op_d      = op_q;
    kill_d    = kill_q;
    dvd_acc_d = dvd_acc_q;
    dvs_acc_d = dvs_acc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          src1_d    = req_src1;
          src2_d    = req_src2;
          op_d      = req_op;
          kill_d    = 1'b0;
          dvd_acc_d = 1'b0;
          dvs_acc_d = 1'b0;
          if (!req_onehot) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cache_hit) begin
            res_d   = req_quot ? cache_dout[63:32] : cache_dout[31:0];
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        dvd_acc_d = dvd_done;
        dvs_acc_d = dvs_done;
        // nothing reached the IP yet: safe to abandon outright
        if (flush && !dvd_done && !dvs_done) begin
          state_d = S_IDLE;
        end else begin
          if (flush) kill_d = 1'b1;
          if (dvd_done && dvs_done) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (sel_dout_tvalid) begin
          if (kill_q || flush) begin
            state_d = S_IDLE;
          end else begin
            res_d   = sel_half;
            err_d   = 1'b0;
            state_d = S_DONE;
          end
        end else if (timeout) begin
          if (kill_q || flush) begin
            state_d = S_IDLE;
          end else begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      src1_q    <= '0;
      src2_q    <= '0;
      op_q      <= '0;
      kill_q    <= 1'b0;
      dvd_acc_q <= 1'b0;
      dvs_acc_q <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      op_q      <= op_d;
      kill_q    <= kill_d;
      dvd_acc_q <= dvd_acc_d;
      dvs_acc_q <= dvs_acc_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign req_ready            = (state_q == S_IDLE);
  assign busy                 = (state_q != S_IDLE);
  assign resp_valid           = (state_q == S_DONE);
  assign resp_result          = res_q;
  assign resp_err             = err_q;
  assign div_src1             = src1_q;
  assign div_src2             = src2_q;
  assign sdiv_dividend_tvalid = dvd_tvalid & sel_signed;
  assign sdiv_divisor_tvalid  = dvs_tvalid & sel_signed;
  assign udiv_dividend_tvalid = dvd_tvalid & ~sel_signed;
  assign udiv_divisor_tvalid  = dvs_tvalid & ~sel_signed;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: table vectors, directed multi-cycle sequences and random
// traffic against a behavioural divider-IP model and reference result model.
module tb_div_issue_ctrl;

`ifdef DIV_PAIR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [3:0] DIV = 4'b0001, DIVU = 4'b0010, MOD = 4'b0100, MODU = 4'b1000;

  logic        clk, resetn, req_valid, req_ready, flush, resp_valid, resp_ready, resp_err, busy;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2, resp_result, div_src1, div_src2;
  logic        sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid;

  // divider IP model state (index 0 = signed IP, 1 = unsigned IP)
  logic        dvd_rdy [2];
  logic        dvs_rdy [2];
  logic        dout_v  [2];
  logic [63:0] dout_d  [2];
  logic        got_a   [2];
  logic        got_b   [2];
  logic [31:0] ipa     [2];
  logic [31:0] ipb     [2];
  logic [63:0] ipres   [2];
  int          cd      [2];
  int          age     [2];
  int          ip_lat, dvs_delay;
  bit          ip_drop, ip_override;

  int n_checks, n_fail, s_hs, u_hs, s_tv, u_tv, tr_n;
  bit tr_dvd [16];
  bit tr_dvs [16];

  div_issue_ctrl #(.MAX_WAIT(64), .CNT_W(7)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy), .div_src1(div_src1), .div_src2(div_src2),
    .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_divisor_tvalid(sdiv_divisor_tvalid),
    .sdiv_dividend_tready(dvd_rdy[0]), .sdiv_divisor_tready(dvs_rdy[0]),
    .sdiv_dout_tdata(dout_d[0]), .sdiv_dout_tvalid(dout_v[0]),
    .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_divisor_tvalid(udiv_divisor_tvalid),
    .udiv_dividend_tready(dvd_rdy[1]), .udiv_divisor_tready(dvs_rdy[1]),
    .udiv_dout_tdata(dout_d[1]), .udiv_dout_tvalid(dout_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // what a divider IP returns: {quotient, remainder}; divide by zero gives all-ones / dividend
  function automatic logic [63:0] ip_calc(bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  // expected response from the instruction semantics
  task automatic ref_resp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic err);
    logic [63:0] ipv;
    res = '0;
    err = 1'b0;
    case (op)
      DIV:     begin ipv = ip_calc(1'b1, a, b); res = ipv[63:32]; end
      DIVU:    begin ipv = ip_calc(1'b0, a, b); res = ipv[63:32]; end
      MOD:     begin ipv = ip_calc(1'b1, a, b); res = ipv[31:0];  end
      MODU:    begin ipv = ip_calc(1'b0, a, b); res = ipv[31:0];  end
      default: err = 1'b1;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ip_clear();
    for (int k = 0; k < 2; k++) begin
      got_a[k] = 0; got_b[k] = 0; cd[k] = 0; age[k] = 0;
      dout_v[k] = 0; dout_d[k] = '0; dvd_rdy[k] = 1; dvs_rdy[k] = 1;
    end
  endtask

  // IP behaviour for the cycle that has just started
  task automatic ip_update();
    for (int k = 0; k < 2; k++) begin
      dout_v[k] = 1'b0;
      if (got_a[k] && got_b[k]) begin
        ipres[k] = ip_calc(k == 0, ipa[k], ipb[k]);
        cd[k]    = ip_lat;
        got_a[k] = 0;
        got_b[k] = 0;
      end
      if (cd[k] > 0) begin
        cd[k]--;
        if (cd[k] == 0 && !ip_drop) begin
          dout_v[k] = 1'b1;
          dout_d[k] = ip_override ? {32'h1234_5678, 32'h0} : ipres[k];
        end
      end
      if (got_a[k] && !got_b[k]) age[k]++;
      dvs_rdy[k] = (dvs_delay == 0) || (got_a[k] && !got_b[k] && age[k] >= dvs_delay);
      dvd_rdy[k] = 1'b1;
    end
  endtask

  // one clock: note handshakes due at the coming edge, then advance to the next negedge
  task automatic tick();
    if (tr_n < 16) begin
      tr_dvd[tr_n] = sdiv_dividend_tvalid;
      tr_dvs[tr_n] = sdiv_divisor_tvalid;
    end
    tr_n++;
    if (sdiv_dividend_tvalid || sdiv_divisor_tvalid) s_tv++;
    if (udiv_dividend_tvalid || udiv_divisor_tvalid) u_tv++;
    if (sdiv_dividend_tvalid && dvd_rdy[0]) begin ipa[0] = div_src1; got_a[0] = 1; age[0] = 0; s_hs++; end
    if (sdiv_divisor_tvalid  && dvs_rdy[0]) begin ipb[0] = div_src2; got_b[0] = 1; s_hs++; end
    if (udiv_dividend_tvalid && dvd_rdy[1]) begin ipa[1] = div_src1; got_a[1] = 1; age[1] = 0; u_hs++; end
    if (udiv_divisor_tvalid  && dvs_rdy[1]) begin ipb[1] = div_src2; got_b[1] = 1; u_hs++; end
    @(posedge clk);
    @(negedge clk);
    ip_update();
  endtask

  // issue one request, wait (bounded) for the response, hold it, then consume it
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] res, output logic err,
                        output int lat, output bit got);
    req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    s_hs = 0; u_hs = 0; s_tv = 0; u_tv = 0; tr_n = 0;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      tick();
      lat++;
    end
    got = resp_valid;
    res = resp_result;
    err = resp_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_result", resp_result, res);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    $display("txn op=%b a=%h b=%h -> got=%0d result=%h err=%0d lat=%0d", op, a, b, got, res, err, lat);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_err;
    logic        exp_signed;
    bit          hit;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] res, exp_res, ra, rb;
  logic [3:0]  rop;
  logic        err, exp_err;
  int          lat, n_rv, exp_lat, exp_hs;
  bit          got;

  initial begin
    tbl[0] = '{DIV,     32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{MOD,     32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{DIVU,    32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{MODU,    32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{DIV,     32'd100,       32'd7,         32'd14,        1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'b0011, 32'd100,       32'd7,         32'd0,         1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'b0000, 32'd9,         32'd3,         32'd0,         1'b1, 1'b0, 1'b0};
    tbl[7] = '{DIV,     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{DIVU,    32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{MOD,     32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 1'b1, 1'b0};

    n_checks = 0; n_fail = 0; tr_n = 0; s_hs = 0; u_hs = 0; s_tv = 0; u_tv = 0;
    ip_lat = 1; dvs_delay = 0; ip_drop = 0; ip_override = 0;
    ip_clear();
    resetn = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_src1 = '0; req_src2 = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_tvalids", {sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);
    chk("rst_div_src1", div_src1, 0);
    chk("rst_div_src2", div_src2, 0);
    resetn = 1'b1;
    tick();

    // table vectors, single-cycle IP latency, no stalls
    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, err, lat, got);
      exp_lat = (tbl[i].exp_err || (CACHE && tbl[i].hit)) ? 1 : 3;
      exp_hs  = (tbl[i].exp_err || (CACHE && tbl[i].hit)) ? 0 : 2;
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
      chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("vec%0d_latency", i), lat, exp_lat);
      chk($sformatf("vec%0d_sel_ip_handshakes", i), tbl[i].exp_signed ? s_hs : u_hs, exp_hs);
      chk($sformatf("vec%0d_other_ip_tvalid", i), tbl[i].exp_signed ? u_tv : s_tv, 0);
    end

    // divisor tready three cycles after dividend tready
    dvs_delay = 3;
    do_txn(DIV, 32'h1234, 32'h56, 0, res, err, lat, got);
    chk("skew_result", res, 32'h36);
    chk("skew_both_valid_t1", {tr_dvd[1], tr_dvs[1]}, 2'b11);
    chk("skew_dividend_drop_t2", {tr_dvd[2], tr_dvs[2]}, 2'b01);
    chk("skew_divisor_held_t4", tr_dvs[4], 1);
    chk("skew_divisor_drop_t5", tr_dvs[5], 0);
    chk("skew_latency", lat, 6);
    chk("skew_handshakes", s_hs, 2);
    dvs_delay = 0;

    // flush while waiting: the late IP result must not produce a response
    ip_lat = 5; ip_override = 1;
    req_op = DIV; req_src1 = 32'd3; req_src2 = 32'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_rv = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) n_rv++;
      tick();
    end
    chk("wait_flush_no_resp", n_rv, 0);
    chk("wait_flush_idle", busy, 0);
    ip_lat = 1; ip_override = 0;
    do_txn(DIV, 32'd100, 32'd7, 0, res, err, lat, got);
    chk("after_flush_result", res, 32'd14);
    chk("after_flush_err", err, 0);

    // response held under back-pressure
    do_txn(DIVU, 32'd1000, 32'd9, 5, res, err, lat, got);
    chk("hold_value", res, 32'd111);

    // stuck divider times out after 64 WAIT cycles
    ip_drop = 1;
    do_txn(DIVU, 32'hDEAD_0000, 32'd3, 0, res, err, lat, got);
    chk("timeout_got", got, 1);
    chk("timeout_latency", lat, 66);
    chk("timeout_result", res, 0);
    chk("timeout_err", err, 1);
    ip_drop = 0;

    // flush in DONE drops the response
    req_op = MODU; req_src1 = 32'd50; req_src2 = 32'd7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 200) begin tick(); lat++; end
    chk("done_flush_reached", resp_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_resp_valid", resp_valid, 0);
    chk("done_flush_busy", busy, 0);

    // flush beats a simultaneous request
    req_op = DIV; req_src1 = 32'd77; req_src2 = 32'd11; req_valid = 1'b1; flush = 1'b1;
    s_tv = 0;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_req_busy", busy, 0);
    tick();
    chk("flush_req_no_issue", s_tv, 0);

    // reset pulsed in ISSUE, then a stray IP result
    dvs_delay = 3;
    req_op = DIV; req_src1 = 32'h777; req_src2 = 32'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("issue_before_reset", sdiv_divisor_tvalid, 1);
    resetn = 1'b0;
    #1;
    chk("areset_tvalids", {sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);
    chk("areset_busy", busy, 0);
    chk("areset_resp_valid", resp_valid, 0);
    chk("areset_div_src1", div_src1, 0);
    tick();
    resetn = 1'b1;
    dvs_delay = 0;
    ip_clear();
    dout_v[0] = 1'b1;
    dout_d[0] = {32'hAAAA_5555, 32'h0};
    n_rv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid || busy) n_rv++;
    end
    chk("late_dout_ignored", n_rv, 0);
    chk("post_reset_req_ready", req_ready, 1);

    // random traffic against the reference model
    ra = 32'd1; rb = 32'd1;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 19) == 0) rop = 4'($urandom);
      else rop = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        ra = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      dvs_delay = $urandom_range(0, 2);
      ip_lat    = $urandom_range(1, 4);
      ref_resp(rop, ra, rb, exp_res, exp_err);
      do_txn(rop, ra, rb, $urandom_range(0, 2), res, err, lat, got);
      chk("rand_got", got, 1);
      chk("rand_result", res, exp_res);
      chk("rand_err", err, exp_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencer between the EX-stage ALU and the two pipelined divider IPs: signed `IP_DIV` and unsigned `IP_DIV_U`.
- Accepts one div/mod request at a time on a valid/ready interface and drives the dual-channel AXI-stream issue (dividend and divisor).
- Waits for the IP result, selects quotient or remainder, and returns it on a valid/ready response interface.
- Handles pipeline flush at any point, including discarding an in-flight result, and times out a stuck divider.

Parameters:
- MAX_WAIT, 64: cycles allowed in WAIT before forced error completion.
- CNT_W, 7: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  4  one-hot {modu, mod, divu, div} = bits [3:0]
- req_src1  in  32  dividend (rj)
- req_src2  in  32  divisor (rk)
- flush  in  1  cancel current operation
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_result  out  32  quotient or remainder
- resp_err  out  1  result produced by timeout; resp_result = 0
- busy  out  1  state != IDLE
- div_src1  out  32  registered dividend to both IPs
- div_src2  out  32  registered divisor to both IPs
- sdiv_dividend_tvalid / sdiv_divisor_tvalid  out  1 each  signed IP input valids
- sdiv_dividend_tready / sdiv_divisor_tready  in  1 each
- sdiv_dout_tdata  in  64  {quotient, remainder}
- sdiv_dout_tvalid  in  1
- udiv_*  same six ports for the unsigned IP

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, all tvalids=0, resp_valid=0, resp_err=0, resp_result=0, busy=0.
  - kill flag=0, accepted flags=0, wait counter=0.
  - div_src1/div_src2=0.
- Signedness and result select:
  - signed = div|mod; selects the sdiv port set, otherwise the udiv set.
  - div/divu return dout[63:32]; mod/modu return dout[31:0].
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && !flush: latch src1/src2/op, clear kill and accepted flags, go to ISSUE.
  - tvalids rise the cycle after acceptance.
  - flush and req_valid in the same cycle: flush wins, nothing is accepted.
  - Multiple or zero bits set in req_op: request accepted and ignored; go to DONE with resp_result=0, resp_err=1.
- ISSUE:
  - Assert both tvalids of the selected IP.
  - Each channel deasserts its tvalid the cycle after its own tvalid&&tready; the two channels may complete in different cycles.
  - When both are accepted, go to WAIT and clear the counter.
  - flush with neither channel accepted: drop tvalids, go to IDLE.
  - flush after one or both channels accepted: set kill, finish the outstanding channel, proceed normally.
- WAIT:
  - The counter increments each cycle.
  - On selected dout_tvalid:
    - if kill, or flush in the same cycle: go to IDLE, no response.
    - else capture the selected half into resp_result and go to DONE.
  - The non-selected IP's dout_tvalid is ignored.
  - flush in WAIT sets kill; the IP result is still awaited so it is not mistaken for a later request.
  - Counter reaches MAX_WAIT without dout_tvalid:
    - kill=0: go to DONE with resp_err=1, resp_result=0.
    - kill=1: go to IDLE.
- DONE:
  - resp_valid=1; resp_result and resp_err are stable until resp_valid&&resp_ready, then go to IDLE.
  - flush in DONE drops the response and goes to IDLE.
  - resp_ready and flush in the same cycle: flush wins.
- Latency (no stalls): accept at T, tvalid at T+1, WAIT from T+2, resp_valid the cycle after IP dout_tvalid.
- Divisor 0 is passed to the IP unchanged; the result is whatever the IP returns, with no trap.
- Reset asserted mid-operation aborts immediately to IDLE; in-flight IP results arriving later are ignored in IDLE.

Optional Feature:
- DIV_PAIR_CACHE_EN defined:
  - Keeps the last non-killed, non-error result: 64-bit dout plus src1, src2, signed and a valid bit (cleared on reset).
  - A request matching src1, src2 and signedness with valid=1 goes IDLE to DONE directly; resp_valid is asserted the cycle after acceptance and no IP handshake occurs.
  - This serves div followed by mod on the same operands.
  - Cache entries are updated only on a normal WAIT completion.
- Undefined: no cache logic; every request issues to the IP.

Test Plan:
- div: src1=0xFFFFFFF9 (-7), src2=2 -> sdiv tvalids asserted, resp_result=0xFFFFFFFD, resp_err=0. The same operands with mod -> 0xFFFFFFFF; with DIV_PAIR_CACHE_EN, resp_valid the cycle after acceptance and no tvalid.
- divu: 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; modu -> 0x0000000F; udiv ports only, sdiv tvalids stay 0.
- Divisor tready 3 cycles after dividend tready -> dividend tvalid drops first, divisor tvalid held until accepted, WAIT entered only after both.
- flush during WAIT, then IP returns 0x12345678 in the quotient half -> no resp_valid, state IDLE; the next request div 100/7 returns 14.
- resp_ready held 0 for 5 cycles -> resp_valid and resp_result stable throughout. Separately, dout_tvalid never arrives -> after 64 WAIT cycles resp_valid=1, resp_err=1, resp_result=0.
- resetn pulsed low in ISSUE -> all outputs 0 immediately; a late dout_tvalid is ignored; req_ready=1 after release.
